servo_angle_uart_tx: RTL

SERVO_ANGLE_UART_TX -- requirements
Module: servo_angle_uart_tx

---
 rtl/servo_angle_uart_tx_if.sv | 25 ++
 rtl/servo_angle_uart_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/servo_angle_uart_tx_if.sv
// Request/status bundle for the servo angle UART transmitter.
// Handshake: a request is taken on a rising edge where Valid_i=1, Enable_i=1 and Ready_o=1;
// Valid_i with Enable_i=1 while Ready_o=0 is refused and flagged by a one-cycle Drop_o pulse.
interface servo_angle_uart_tx_if #(
    parameter int ANGLE_W = 8
);
    logic               Enable_i;
    logic               Valid_i;
    logic [ANGLE_W-1:0] Angle_i;
    logic               Ready_o;
    logic               Busy_o;
    logic               Drop_o;
    logic               Tx_o;
    logic [2:0]         Dbg_state_o;

    modport master (
        output Enable_i, Valid_i, Angle_i,
        input  Ready_o, Busy_o, Drop_o, Tx_o, Dbg_state_o
    );

    modport slave (
        input  Enable_i, Valid_i, Angle_i,
        output Ready_o, Busy_o, Drop_o, Tx_o, Dbg_state_o
    );
endinterface

// File: rtl/servo_angle_uart_tx.sv
// Converts an unsigned angle to 1..3 ASCII decimal digits (optionally followed by CR LF)
// and shifts them out as back-to-back UART frames.
module servo_angle_uart_tx #(
    parameter int CLK_DIV    = 5208,
    parameter int ANGLE_W    = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int SEND_CRLF  = 1
) (
    input  logic                 Clk_i,
    input  logic                 Reset_i,
    servo_angle_uart_tx_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_START, S_DATA, S_PARITY, S_STOP, S_NEXT
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] BAUD_PRE  = 16'(CLK_DIV - 2);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [2:0]  CRLF_N    = (SEND_CRLF != 0) ? 3'd2 : 3'd0;
    localparam logic        PODD      = (PARITY_ODD != 0);

    state_t      r_state;
    logic [15:0] r_baud;
    logic [2:0]  r_bit;
    logic [2:0]  r_cidx;
    logic [9:0]  r_value;
    logic [3:0]  r_hund;
    logic [3:0]  r_tens;
    logic        r_conv_tens;
    logic        r_tx;
    logic        r_drop;

    state_t      w_state_next;
    logic [15:0] w_baud_next;
    logic [2:0]  w_bit_next;
    logic [2:0]  w_cidx_next;
    logic        w_tx_next;
    logic        w_accept;
    logic        w_baud_end;
    logic        w_conv_done;
    logic [9:0]  w_angle_ext;
    logic [9:0]  w_sat;
    logic [2:0]  w_ndig;
    logic [2:0]  w_total;
    logic [2:0]  w_first;
    logic [2:0]  w_didx;
    logic [3:0]  w_digit;
    logic [7:0]  w_char;

    assign w_accept    = bus.Valid_i & bus.Enable_i & (r_state == S_IDLE);
    assign w_baud_end  = (r_baud == BAUD_LAST);
    assign w_conv_done = r_conv_tens & (r_value < 10'd10);
    assign w_angle_ext = 10'(bus.Angle_i);
    assign w_sat       = (w_angle_ext > 10'd999) ? 10'd999 : w_angle_ext;

    // After conversion r_value holds the ones digit; hundreds/tens stay put for the whole message.
    assign w_ndig  = (r_hund != 4'd0) ? 3'd3 : (r_tens != 4'd0) ? 3'd2 : 3'd1;
    assign w_total = w_ndig + CRLF_N;

    always_comb begin
        w_first = 3'd3 - w_ndig;
        w_didx  = w_first + r_cidx;
        w_digit = r_value[3:0];
        case (w_didx)
            3'd0:    w_digit = r_hund;
            3'd1:    w_digit = r_tens;
            default: w_digit = r_value[3:0];
        endcase
        if (r_cidx < w_ndig)       w_char = {4'h3, w_digit};
        else if (r_cidx == w_ndig) w_char = 8'h0D;
        else                       w_char = 8'h0A;
    end

    // The last cycle of the final stop bit is spent in NEXT so the following start bit is gapless.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud + 16'd1;
        w_bit_next   = r_bit;
        w_cidx_next  = r_cidx;
        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                w_bit_next  = '0;
                w_cidx_next = '0;
                if (w_accept) w_state_next = S_CONV;
            end
            S_CONV: begin
                w_baud_next = '0;
                if (w_conv_done) w_state_next = S_START;
            end
            S_START: begin
                if (w_baud_end) begin
                    w_state_next = S_DATA;
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_next = '0;
                    if (r_bit == 3'd7) begin
                        w_bit_next   = '0;
                        w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_baud_end) begin
                    w_state_next = S_STOP;
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                end
            end
            S_STOP: begin
                if ((r_bit == STOP_LAST) && (r_baud == BAUD_PRE)) begin
                    w_state_next = S_NEXT;
                end else if (w_baud_end) begin
                    w_baud_next = '0;
                    w_bit_next  = r_bit + 3'd1;
                end
            end
            S_NEXT: begin
                w_baud_next = '0;
                w_bit_next  = '0;
                if ((r_cidx + 3'd1) < w_total) begin
                    w_state_next = S_START;
                    w_cidx_next  = r_cidx + 3'd1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_char[w_bit_next];
            S_PARITY: w_tx_next = (^w_char) ^ PODD;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_bit       <= '0;
            r_cidx      <= '0;
            r_value     <= '0;
            r_hund      <= '0;
            r_tens      <= '0;
            r_conv_tens <= 1'b0;
            r_tx        <= 1'b1;
            r_drop      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_cidx  <= w_cidx_next;
            r_tx    <= w_tx_next;
            r_drop  <= bus.Valid_i & bus.Enable_i & (r_state != S_IDLE);
            if (w_accept) begin
                r_value     <= w_sat;
                r_hund      <= '0;
                r_tens      <= '0;
                r_conv_tens <= 1'b0;
            end else if (r_state == S_CONV) begin
                // One subtraction per cycle: hundreds first, then tens.
                if (!r_conv_tens) begin
                    if (r_value >= 10'd100) begin
                        r_value <= r_value - 10'd100;
                        r_hund  <= r_hund + 4'd1;
                    end else begin
                        r_conv_tens <= 1'b1;
                    end
                end else if (r_value >= 10'd10) begin
                    r_value <= r_value - 10'd10;
                    r_tens  <= r_tens + 4'd1;
                end
            end
        end
    end

    assign bus.Ready_o     = (r_state == S_IDLE);
    assign bus.Busy_o      = (r_state != S_IDLE);
    assign bus.Drop_o      = r_drop;
    assign bus.Tx_o        = r_tx;
    assign bus.Dbg_state_o = r_state;
endmodule
